flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of flag-context stack entries; legal values are 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port commit, input, 1 bit: the current ALU instruction retires this cycle, and flag updates are qualified by it.
REQ-005 The block SHALL have port sc_o, input, 1 bit: shift/carry result from the ALU.
REQ-006 The block SHALL have port sc_en, input, 1 bit: load the carry flag from sc_o.
REQ-007 The block SHALL have port sc_clr, input, 1 bit: clear the carry flag.
REQ-008 The block SHALL have port pari, input, 1 bit: parity result from the ALU.
REQ-009 The block SHALL have port pari_en, input, 1 bit: load the parity flag from pari.
REQ-010 The block SHALL have port pari_clr, input, 1 bit: clear the parity flag.
REQ-011 The block SHALL have port push, input, 1 bit: save the current {sc, pari} flag pair onto the stack.
REQ-012 The block SHALL have port pop, input, 1 bit: restore the flag pair from the stack top.
REQ-013 The block SHALL have port err_clr, input, 1 bit: clear the sticky error flag.
REQ-014 The block SHALL have port sc_q, output, 1 bit: registered carry flag, feeding the ALU sc_i.
REQ-015 The block SHALL have port pari_q, output, 1 bit: registered parity flag, feeding the ALU pari_in.
REQ-016 The block SHALL have port depth, output, 4 bits: current stack occupancy, 0..DEPTH.
REQ-017 The block SHALL have port full, output, 1 bit: high when depth equals DEPTH.
REQ-018 The block SHALL have port empty, output, 1 bit: high when depth equals 0.
REQ-019 The block SHALL have port err, output, 1 bit: sticky stack-misuse flag.

Function
REQ-020 Flag updates SHALL occur only in cycles where commit=1; when commit=0, sc_en, sc_clr, pari_en and pari_clr SHALL be ignored.
REQ-021 For the carry flag in a committed cycle, sc_clr SHALL take priority over sc_en: if sc_clr=1 then sc_q becomes 0, else if sc_en=1 then sc_q becomes sc_o, else sc_q holds.
REQ-022 The parity flag SHALL follow the same priority rule as the carry flag, using pari_clr, pari_en and pari.
REQ-023 The carry and parity flags SHALL update independently of each other within the same cycle.
REQ-024 Updated flags SHALL be visible on sc_q and pari_q in the cycle after the edge, with one-cycle latency; no combinational path SHALL exist from any input to sc_q or pari_q.
REQ-025 A legal push (push=1, pop=0, full=0) SHALL write the pre-update {sc_q, pari_q} to entry[depth] and increment depth, and a same-cycle committed flag update SHALL still apply to the live flags.
REQ-026 A legal pop (pop=1, push=0, empty=0) SHALL load the live flags from entry[depth-1] and decrement depth, and the restored value SHALL override any same-cycle committed flag update.
REQ-027 A push while full SHALL leave the stack unchanged and set err, while the committed flag update still applies.
REQ-028 A pop while empty SHALL leave the live flags to follow the normal update rules, leave depth at 0, and set err.
REQ-029 Asserting push and pop in the same cycle SHALL leave the stack and depth unchanged, set err, and still apply the committed flag update.
REQ-030 Once set, err SHALL remain 1 until reset or err_clr=1.
REQ-031 If err_clr=1 in the same cycle as a new error condition, err SHALL end the cycle at 1, because set wins.
REQ-032 full and empty SHALL be decoded from the registered depth.
REQ-033 Stack entries above depth SHALL be don't-care and SHALL never be observable on outputs.

Reset
REQ-034 When reset=1 at a rising edge, the block SHALL set sc_q=0, pari_q=0, depth=0, full=0, empty=1 and err=0, overriding all other inputs.
REQ-035 Reset SHALL NOT be required to clear stack entries, because they are unreachable once depth=0.
REQ-036 Reset asserted mid-sequence, with the stack partly filled, SHALL discard all saved contexts, and the first pop after reset SHALL be treated as an underflow.

Verification
REQ-037 The bench SHALL check: commit=1, sc_en=1, sc_o=1, pari_en=1, pari=1 -> next cycle sc_q=1, pari_q=1; then commit=0, sc_clr=1 -> flags hold at 1.
REQ-038 The bench SHALL check: commit=1, sc_en=1, sc_clr=1, sc_o=1 with sc_q=1 -> next cycle sc_q=0 (clear wins).
REQ-039 The bench SHALL check: flags {1,0}, push with commit=1 and sc_clr=1 -> sc_q=0 and depth=1; then pop -> sc_q=1, pari_q=0, depth=0, empty=1.
REQ-040 The bench SHALL check: DEPTH=4, five consecutive pushes -> depth=4, full=1, err=1 after the fifth push; then err_clr=1 -> err=0 and depth stays 4.
REQ-041 The bench SHALL check: pop at depth=0 -> err=1, depth=0; and push with pop at depth=2 -> depth stays 2 and err=1.
REQ-042 The bench SHALL check: three pushes, then reset for one cycle -> sc_q=0, pari_q=0, depth=0, empty=1, err=0; a following pop -> err=1.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: carry/parity flag registers for the ALU, with a small LIFO stack
// for saving and restoring the flag pair, and a sticky stack-misuse error flag.
module flag_unit #(
    parameter int DEPTH = 4              // stack entries, 2..8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       commit,
    input  logic       sc_o,
    input  logic       sc_en,
    input  logic       sc_clr,
    input  logic       pari,
    input  logic       pari_en,
    input  logic       pari_clr,
    input  logic       push,
    input  logic       pop,
    input  logic       err_clr,
    output logic       sc_q,
    output logic       pari_q,
    output logic [3:0] depth,
    output logic       full,
    output logic       empty,
    output logic       err
);

    // Live state
    logic       sc_d;
    logic       pari_d;
    logic [3:0] depth_q;
    logic [3:0] depth_d;
    logic       err_q;
    logic       err_d;

    // Stack storage: each entry holds {sc, pari}
    logic [1:0]       entry_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic [1:0]       top_data;
    logic [3:0]       top_idx;

    // Stack operation decode
    logic do_push;
    logic do_pop;
    logic err_set;

    assign full  = (depth_q == 4'(DEPTH));
    assign empty = (depth_q == 4'd0);
    assign depth = depth_q;
    assign err   = err_q;

    // Classify the stack request; any illegal combination raises the error
    always_comb begin
        do_push = push && !pop && !full;
        do_pop  = pop && !push && !empty;
        err_set = (push && pop) || (push && !pop && full) || (pop && !push && empty);
    end

    // Per-entry write enable: a push lands in the slot just above the top
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = do_push && (depth_q == 4'(gi));
        end
    endgenerate

    // Read the current top of stack (only meaningful when depth is non-zero)
    always_comb begin
        top_idx  = depth_q - 4'd1;
        top_data = 2'b00;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == 4'(i)) begin
                top_data = entry_q[i];
            end
        end
    end

    // Next live flags: committed update with clear over load; a legal pop
    // restores the saved pair and overrides the update
    always_comb begin
        sc_d   = sc_q;
        pari_d = pari_q;
        if (commit) begin
            if (sc_clr) begin
                sc_d = 1'b0;
            end else if (sc_en) begin
                sc_d = sc_o;
            end
            if (pari_clr) begin
                pari_d = 1'b0;
            end else if (pari_en) begin
                pari_d = pari;
            end
        end
        if (do_pop) begin
            sc_d   = top_data[1];
            pari_d = top_data[0];
        end
    end

    // Next occupancy and sticky error (a new error beats err_clr)
    always_comb begin
        depth_d = depth_q;
        if (do_push) begin
            depth_d = depth_q + 4'd1;
        end else if (do_pop) begin
            depth_d = depth_q - 4'd1;
        end
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Live state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sc_q    <= 1'b0;
            pari_q  <= 1'b0;
            depth_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            sc_q    <= sc_d;
            pari_q  <= pari_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack entries are not reset: they are unreachable once depth is 0
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i] && !reset) begin
                entry_q[i] <= {sc_q, pari_q};
            end
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: table-driven check of flag_unit (DEPTH=4) with a scoreboard
// queue of expected outputs, plus hand-written LIFO and timing sequences.
module tb_flag_unit;

    logic       clk = 1'b0;
    logic       reset, commit, sc_o, sc_en, sc_clr, pari, pari_en, pari_clr;
    logic       push, pop, err_clr;
    logic       sc_q, pari_q, full, empty, err;
    logic [3:0] depth;

    flag_unit #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .commit(commit), .sc_o(sc_o), .sc_en(sc_en),
        .sc_clr(sc_clr), .pari(pari), .pari_en(pari_en), .pari_clr(pari_clr),
        .push(push), .pop(pop), .err_clr(err_clr), .sc_q(sc_q), .pari_q(pari_q),
        .depth(depth), .full(full), .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    // Stimulus bit masks
    localparam logic [10:0] RST = 11'h400, CM = 11'h200, SCO = 11'h100, SCE = 11'h080;
    localparam logic [10:0] SCC = 11'h040, PI = 11'h020, PE = 11'h010, PC = 11'h008;
    localparam logic [10:0] PU = 11'h004, PO = 11'h002, EC = 11'h001, NONE = 11'h000;

    typedef struct {
        string      name;
        logic [10:0] stim;
        logic       sc;
        logic       pari;
        logic [3:0] depth;
        logic       full;
        logic       empty;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(string n, logic [10:0] s, logic e_sc, logic e_pari,
                                logic [3:0] e_depth, logic e_full, logic e_empty, logic e_err);
        vec_t v;
        v.name = n; v.stim = s; v.sc = e_sc; v.pari = e_pari;
        v.depth = e_depth; v.full = e_full; v.empty = e_empty; v.err = e_err;
        return v;
    endfunction

    task automatic chk(string n, int act, int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", n, act, expv);
    endtask

    task automatic set_inputs(logic [10:0] s);
        reset = s[10]; commit = s[9]; sc_o = s[8]; sc_en = s[7]; sc_clr = s[6];
        pari = s[5]; pari_en = s[4]; pari_clr = s[3]; push = s[2]; pop = s[1];
        err_clr = s[0];
    endtask

    // Pop one expected record and compare all outputs against it
    task automatic compare_outputs();
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.name, ".sc_q"},   int'(sc_q),   int'(e.sc));
        chk({e.name, ".pari_q"}, int'(pari_q), int'(e.pari));
        chk({e.name, ".depth"},  int'(depth),  int'(e.depth));
        chk({e.name, ".full"},   int'(full),   int'(e.full));
        chk({e.name, ".empty"},  int'(empty),  int'(e.empty));
        chk({e.name, ".err"},    int'(err),    int'(e.err));
        $display("step %-14s stim=%03h sc=%0b pari=%0b depth=%0d full=%0b empty=%0b err=%0b",
                 e.name, e.stim, sc_q, pari_q, depth, full, empty, err);
    endtask

    // One transaction: drive, enqueue expectation, clock, compare 1 time unit later
    task automatic apply(vec_t v);
        set_inputs(v.stim);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    logic       live_sc, live_pari, exp_err;
    logic [1:0] saved[$];
    logic [1:0] r;
    logic [10:0] s;

    initial begin
        set_inputs(NONE);

        //                  name          stimulus                    sc pa dep fu em er
        vecs.push_back(mk("reset",       RST,                         0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("load_both",   CM|SCE|SCO|PE|PI,            1, 1, 0, 0, 1, 0));
        vecs.push_back(mk("nocommit_clr",SCC,                         1, 1, 0, 0, 1, 0));
        vecs.push_back(mk("clr_wins",    CM|SCE|SCC|SCO,              0, 1, 0, 0, 1, 0));
        vecs.push_back(mk("set_10",      CM|SCE|SCO|PC,               1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("push_upd",    PU|CM|SCC,                   0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pop_restore", PO,                          1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("push1",       PU,                          1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("push2",       PU,                          1, 0, 2, 0, 0, 0));
        vecs.push_back(mk("push3_upd",   PU|CM|PE|PI,                 1, 1, 3, 0, 0, 0));
        vecs.push_back(mk("push4_full",  PU,                          1, 1, 4, 1, 0, 0));
        vecs.push_back(mk("push5_ovf",   PU|CM|SCC,                   0, 1, 4, 1, 0, 1));
        vecs.push_back(mk("err_clr_f",   EC,                          0, 1, 4, 1, 0, 0));
        vecs.push_back(mk("pop_override",PO|CM|SCE|PC,                1, 1, 3, 0, 0, 0));
        vecs.push_back(mk("pop_d2",      PO,                          1, 0, 2, 0, 0, 0));
        vecs.push_back(mk("push_pop",    PU|PO|CM|PE|PI,              1, 1, 2, 0, 0, 1));
        vecs.push_back(mk("err_clr2",    EC,                          1, 1, 2, 0, 0, 0));
        vecs.push_back(mk("pop_d1",      PO,                          1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("pop_d0",      PO,                          1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("pop_underflw",PO|CM|SCC,                   0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("set_beats_clr",PO|EC,                      0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("err_clr3",    EC,                          0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("set_sc",      CM|SCE|SCO,                  1, 0, 0, 0, 1, 0));
        vecs.push_back(mk("rpush1",      PU,                          1, 0, 1, 0, 0, 0));
        vecs.push_back(mk("rpush2",      PU,                          1, 0, 2, 0, 0, 0));
        vecs.push_back(mk("rpush3",      PU,                          1, 0, 3, 0, 0, 0));
        vecs.push_back(mk("mid_reset",   RST|CM|SCE|SCO|PE|PI|PU,     0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("pop_after_rst",PO,                         0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("err_clr4",    EC,                          0, 0, 0, 0, 1, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Hand-written: fill with distinct flag pairs, overflow, then drain in LIFO order
        live_sc = 1'b0; live_pari = 1'b0; exp_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            saved.push_back({live_sc, live_pari});
            s = PU | CM | PE | SCE;
            if (k[0]) s = s | PI;
            if (k[1]) s = s | SCO;
            live_sc = k[1]; live_pari = k[0];
            apply(mk($sformatf("fill%0d", k), s, live_sc, live_pari, 4'(k + 1),
                     (k == 3), 1'b0, 1'b0));
        end
        exp_err = 1'b1;
        apply(mk("fill_ovf", PU, live_sc, live_pari, 4'd4, 1'b1, 1'b0, exp_err));
        for (int k = 3; k >= 0; k--) begin
            r = saved.pop_back();
            apply(mk($sformatf("drain%0d", k), PO | CM | SCC | PC, r[1], r[0], 4'(k),
                     1'b0, (k == 0), exp_err));
        end

        // Hand-written: no combinational path from inputs to the flags
        live_sc = sc_q; live_pari = pari_q;
        set_inputs(CM | SCE | SCO | PE | PI | EC);
        #2;
        chk("no_comb_sc", int'(sc_q), int'(live_sc));
        chk("no_comb_pari", int'(pari_q), int'(live_pari));
        exp_q.push_back(mk("comb_edge", CM | SCE | SCO | PE | PI | EC, 1, 1, 0, 0, 1, 0));
        @(posedge clk);
        #1;
        compare_outputs();

        set_inputs(NONE);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
